// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 device-to-host frame receiver feeding a show-ahead FIFO.
//               Define PS2_RX_ERR_CNT_EN to include the saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    input  logic                            read_n,
    input  logic                            ovf_clr,
    output logic [7:0]                      data,
    output logic                            ready,
    output logic [$clog2(FIFO_DEPTH)+1-1:0] level,
    output logic                            overflow,
    output logic                            frame_err,
    output logic [7:0]                      err_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);

    // Synchroniser and edge-detect flops idle high so reset release is edge-free.
    logic clk_s1, clk_s2, clk_s3;
    logic data_s1, data_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    logic        strobe;
    logic        last_bit;
    logic [9:0]  shift;
    logic [10:0] frame_w;
    logic        frame_ok;
    logic [3:0]  bit_cnt;
    logic [TW-1:0] tcnt;
    logic        timeout_hit;
    logic        err_event;
    logic        push;

    assign strobe   = clk_s3 & ~clk_s2;
    assign last_bit = (bit_cnt == 4'd10);

    // frame_w is the full 11-bit frame as it stands once the current bit lands:
    // [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
    assign frame_w  = {data_s2, shift};
    assign frame_ok = ~frame_w[0] & (^frame_w[9:1]) & frame_w[10];

    assign timeout_hit = (bit_cnt != 4'd0) & ~strobe & (tcnt == TIMEOUT_VAL);
    assign err_event   = (strobe & last_bit & ~frame_ok) | timeout_hit;
    assign push        = strobe & last_bit & frame_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift     <= '0;
            bit_cnt   <= 4'd0;
            tcnt      <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_event;
            if (strobe) begin
                shift   <= frame_w[10:1];
                bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
                tcnt    <= '0;
            end else if (bit_cnt == 4'd0) begin
                tcnt    <= '0;
            end else if (timeout_hit) begin
                bit_cnt <= 4'd0;
                tcnt    <= '0;
            end else begin
                tcnt    <= tcnt + TW'(1);
            end
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full;
    logic          pop;
    logic          do_push;
    logic          ovf_set;

    assign ready   = (level != '0);
    assign full    = (level == FULL_LEVEL);
    assign pop     = ~read_n & ready;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | pop);
    assign ovf_set = push & full & ~pop;
    assign data    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= frame_w[8:1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef PS2_RX_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 8'd0;
        end else if (ovf_clr) begin
            err_cnt_r <= frame_err ? 8'd1 : 8'd0;
        end else if (frame_err && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// Testbench for ps2_rx_fifo: directed PS/2 frames with immediate-assertion checks.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       read_n = 1'b1;
    logic       ovf_clr = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic [3:0] level;
    logic       overflow;
    logic       frame_err;
    logic [7:0] err_cnt;

    int total = 0;
    int bad = 0;
    int err_pulses = 0;
    int base;

`ifdef PS2_RX_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .read_n    (read_n),
        .ovf_clr   (ovf_clr),
        .data      (data),
        .ready     (ready),
        .level     (level),
        .overflow  (overflow),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
        mk_frame = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Sends the first n bits of fr; ps2_clk falls on a clk negedge so the push
    // cycle of the final bit is the 2nd..3rd negedge after that fall.
    task automatic send_bits(input logic [10:0] fr, input int n,
                             input bit pop_at_push, input bit clr_at_push);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == n - 1 && (pop_at_push || clr_at_push)) begin
                repeat (2) @(negedge clk);
                if (pop_at_push) read_n = 1'b0;
                if (clr_at_push) ovf_clr = 1'b1;
                @(negedge clk);
                read_n = 1'b1;
                ovf_clr = 1'b0;
                repeat (7) @(negedge clk);
            end else begin
                repeat (10) @(negedge clk);
            end
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0), 11, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        @(negedge clk);
        read_n = 1'b0;
        @(negedge clk);
        read_n = 1'b1;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Valid frame 0x1C then a single pop
        send_byte(8'h1C);
        chk("v_ready", ready, 1);
        chk("v_data", data, 8'h1C);
        chk("v_level", level, 1);
        pop_one();
        chk("pop_ready", ready, 0);
        chk("pop_level", level, 0);
        pop_one();
        chk("empty_pop_level", level, 0);

        // Parity error
        base = err_pulses;
        send_bits(mk_frame(8'h1C, 1'b1), 11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("par_pulses", err_pulses - base, 1);
        chk("par_ready", ready, 0);
        chk("par_err_cnt", err_cnt, CNT_ON ? 1 : 0);

        // Empty pop earlier must not have disturbed pointers
        send_byte(8'h3A);
        chk("after_empty_pop_data", data, 8'h3A);
        pop_one();

        // Overflow: 9 frames, the 9th pushed in the same cycle as ovf_clr
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        chk("full_level", level, 8);
        chk("full_no_ovf", overflow, 0);
        send_bits(mk_frame(8'h09, 1'b0), 11, 1'b0, 1'b1);
        chk("ovf_level", level, 8);
        chk("ovf_set_wins_clr", overflow, 1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ovf_read%0d", i), data, i);
            pop_one();
        end
        chk("drained_level", level, 0);
        pulse_clr();
        chk("ovf_cleared", overflow, 0);
        chk("clr_err_cnt", err_cnt, 0);

        // Full FIFO with a pop in the push cycle
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
        send_bits(mk_frame(8'h55, 1'b0), 11, 1'b1, 1'b0);
        chk("pp_overflow", overflow, 0);
        chk("pp_level", level, 8);
        chk("pp_head", data, 8'h11);
        for (int i = 0; i < 7; i++) pop_one();
        chk("pp_last", data, 8'h55);
        pop_one();
        chk("pp_empty", ready, 0);

        // Timeout of a partial frame
        base = err_pulses;
        send_bits(mk_frame(8'hC3, 1'b0), 4, 1'b0, 1'b0);
        repeat (150) @(negedge clk);
        chk("tmo_early", err_pulses - base, 0);
        repeat (100) @(negedge clk);
        chk("tmo_pulse", err_pulses - base, 1);
        chk("tmo_err_cnt", err_cnt, CNT_ON ? 1 : 0);
        send_byte(8'hF0);
        chk("tmo_next_data", data, 8'hF0);
        chk("tmo_next_level", level, 1);
        chk("tmo_no_more_err", err_pulses - base, 1);
        pop_one();

        // Reset mid-frame with bytes queued
        send_byte(8'h21);
        send_byte(8'h22);
        send_byte(8'h23);
        chk("q_level", level, 3);
        send_bits(mk_frame(8'h77, 1'b0), 5, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_ready", ready, 0);
        chk("mr_level", level, 0);
        chk("mr_overflow", overflow, 0);
        chk("mr_err_cnt", err_cnt, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(8'hAA);
        chk("mr_data", data, 8'hAA);
        chk("mr_level_after", level, 1);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of 2, >= 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, clk cycles of ps2_clk inactivity that abort a partial frame.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  PS/2 clock from device, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  PS/2 data from device, asynchronous to clk.
REQ-007 SHALL have port read_n  input  1  active-low pop strobe, one entry per cycle held low.
REQ-008 SHALL have port ovf_clr  input  1  clears the overflow flag.
REQ-009 SHALL have port data  output  8  FIFO head, show-ahead, valid while ready=1.
REQ-010 SHALL have port ready  output  1  FIFO non-empty.
REQ-011 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port overflow  output  1  sticky, a valid frame was dropped.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on a rejected or timed-out frame.
REQ-014 SHALL have port err_cnt  output  8  saturating error count (see Configuration).

Function
REQ-015 SHALL synchronise ps2_clk and ps2_data through two flops each, then detect a ps2_clk falling edge with one further flop; a sample strobe is asserted for one clk cycle per edge.
REQ-016 SHALL shift the synchronised ps2_data on each strobe into an 11-bit frame: start, 8 data LSB-first, parity, stop, with bit counter 0..10.
REQ-017 SHALL accept a frame on the 11th strobe only when start=0, data+parity has odd parity, and stop=1; otherwise drop it and pulse frame_err.
REQ-018 SHALL reset the bit counter to 0 after the 11th strobe, whether the frame is accepted or rejected.
REQ-019 SHALL write an accepted byte at the clk edge that ends the 11th strobe cycle; ready, level and data SHALL reflect it on the following cycle.
REQ-020 SHALL pop the head when read_n=0 and ready=1; read_n=0 while empty SHALL be ignored with no pointer change.
REQ-021 SHALL, when a push and a pop occur in the same cycle, perform both with level unchanged; this includes the full case, where the push is accepted and no overflow occurs.
REQ-022 SHALL, on a push while full without a pop, drop the byte, keep the FIFO contents, and set overflow.
REQ-023 SHALL hold overflow until an ovf_clr cycle; a new overflow in the same cycle as ovf_clr SHALL leave overflow set.
REQ-024 SHALL wrap read and write pointers modulo FIFO_DEPTH, with full/empty derived from level.
REQ-025 SHALL run a timeout counter while the bit counter is nonzero, cleared on every strobe; on reaching TIMEOUT_CYCLES it SHALL reset the bit counter to 0 and pulse frame_err.
REQ-026 SHALL keep the timeout counter at 0 while the bit counter is 0.

Reset
REQ-027 SHALL, while rst_n=0, clear pointers, level, bit counter, timeout counter, shift register and err_cnt to 0, and drive ready, overflow and frame_err to 0.
REQ-028 SHALL preset the synchroniser flops to 1 (PS/2 idle level) so that reset release does not cause a false edge.
REQ-029 SHALL, on reset asserted mid-frame or with the FIFO non-empty, discard all partial and stored data; the first strobe after release is treated as a start bit.

Configuration
REQ-030 SHALL, with macro PS2_RX_ERR_CNT_EN defined, increment err_cnt on each frame_err pulse, saturating at 255; the counter SHALL be cleared by ovf_clr, and an error in the clear cycle SHALL yield 1.
REQ-031 SHALL, without PS2_RX_ERR_CNT_EN, drive err_cnt to constant 0 and contain no counter logic; all other behaviour SHALL be identical.

Verification
REQ-032 SHALL verify: send valid frame 0x1C (parity 0, stop 1) -> ready=1, data=0x1C, level=1; pulse read_n low for one cycle -> ready=0, level=0.
REQ-033 SHALL verify: send 0x1C with parity bit 1 -> frame_err pulses once, ready stays 0, err_cnt=1 (macro on) or 0 (macro off).
REQ-034 SHALL verify: with FIFO_DEPTH=8, send 9 frames 0x01..0x09 with no reads -> level=8, overflow=1, reads return 0x01..0x08; then ovf_clr -> overflow=0.
REQ-035 SHALL verify: with FIFO full, hold read_n low across the push cycle of frame 0x55 -> overflow stays 0, level stays 8, 0x55 is the last byte read.
REQ-036 SHALL verify: send 4 bits then idle ps2_clk high for TIMEOUT_CYCLES -> frame_err pulses once; a following valid 0xF0 frame is received correctly.
REQ-037 SHALL verify: assert rst_n low after bit 5 of a frame with 3 bytes queued -> ready=0, level=0, overflow=0; after release, a valid 0xAA frame yields data=0xAA.
